// File: rtl/batcharger_ctrl.sv
// ----------------------------------------------------------------------------
// batcharger_ctrl
//
// Purpose:
//    Li-ion charge controller. Walks a battery through trickle charge (TC),
//    constant current (CC), constant voltage (CV) and DONE. It recharges from
//    DONE when the cell sags, and drops into FAULT whenever the temperature
//    leaves the allowed window. Every data-driven decision is taken only on
//    ADC sample strobes. Each decision needs DEBOUNCE consecutive qualifying
//    samples, except the temperature trip, which fires on a single sample.
//
// Ports:
//    clk         in   1  clock
//    rst         in   1  synchronous active-high reset
//    en          in   1  charger enable; low forces IDLE on the next clock
//    sel         in   4  capacity select, C = 50*(sel+1) mAh, latched on start
//    smp_vld     in   1  one-cycle strobe qualifying the three ADC codes
//    vbat_code   in   8  battery voltage, 20 mV/LSB
//    ibat_code   in   8  battery current, 5 mA/LSB
//    vtemp_code  in   8  temperature, 0..255 maps to -40..125 C
//    tc          out  1  trickle-charge state active
//    cc          out  1  constant-current state active
//    cv          out  1  constant-voltage state active
//    done        out  1  charge complete
//    fault       out  1  temperature fault
//    icode       out  8  current DAC command, 5 mA/LSB
//    vcode       out  8  voltage DAC target, 20 mV/LSB
// ----------------------------------------------------------------------------
module batcharger_ctrl #(
   parameter logic [2:0]  DEBOUNCE = 3'd4,
   parameter logic [7:0]  VCUT     = 8'd150,
   parameter logic [7:0]  VPRE     = 8'd210,
   parameter logic [7:0]  VRECH    = 8'd195,
   parameter logic [7:0]  TLO      = 8'd62,
   parameter logic [7:0]  THI      = 8'd131,
   parameter logic [15:0] CV_TMAX  = 16'd40000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [3:0] sel,
   input  logic       smp_vld,
   input  logic [7:0] vbat_code,
   input  logic [7:0] ibat_code,
   input  logic [7:0] vtemp_code,
   output logic       tc,
   output logic       cc,
   output logic       cv,
   output logic       done,
   output logic       fault,
   output logic [7:0] icode,
   output logic [7:0] vcode
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_TC    = 3'd1,
      ST_CC    = 3'd2,
      ST_CV    = 3'd3,
      ST_DONE  = 3'd4,
      ST_FAULT = 3'd5
   } state_t;

   state_t      state_q, state_d;
   logic [2:0]  deb_q, deb_d;
   logic [15:0] cv_cnt_q, cv_cnt_d;
   logic [3:0]  cap_q, cap_d;

   logic [7:0]  cap_p1;
   logic [7:0]  i_cc;
   logic [7:0]  i_end;
   logic        temp_ok;
   logic        qualify;
   logic [2:0]  deb_inc;
   logic        deb_done;
   logic [15:0] cv_inc;
   logic        cv_timeout;

   // Charge currents scale with the capacity latched at charge start.
   // I_CC is 10*(cap+1); it is built from two shifts so no multiplier is
   // needed. The largest value, 160, still fits in 8 bits.
   always_comb begin
      cap_p1 = {4'd0, cap_q} + 8'd1;
      i_cc   = (cap_p1 << 3) + (cap_p1 << 1);
      i_end  = cap_p1;
   end

   // This block decides whether the current sample counts toward the pending
   // transition of the present state. It also computes the saturating
   // increments of the debounce counter and the CV counter. A debounce
   // completes on the sample that would bring the counter up to DEBOUNCE.
   // The CV timeout fires on the sample whose incremented count reaches
   // CV_TMAX.
   always_comb begin
      temp_ok = (vtemp_code >= TLO) && (vtemp_code <= THI);
      case (state_q)
         ST_TC:    qualify = (vbat_code >= VCUT);
         ST_CC:    qualify = (vbat_code >= VPRE);
         ST_CV:    qualify = (ibat_code <= i_end);
         ST_DONE:  qualify = (vbat_code < VRECH);
         ST_FAULT: qualify = temp_ok;
         default:  qualify = 1'b0;
      endcase
      deb_inc    = (deb_q >= DEBOUNCE) ? deb_q : deb_q + 3'd1;
      deb_done   = qualify && (deb_inc >= DEBOUNCE);
      cv_inc     = (cv_cnt_q == 16'hFFFF) ? cv_cnt_q : cv_cnt_q + 16'd1;
      cv_timeout = (state_q == ST_CV) && (cv_inc >= CV_TMAX);
   end

   // This is the state register. Reset is synchronous and overrides
   // everything, so a charge in progress is cut off on the very next edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // This block computes the next state. Dropping en returns to IDLE
   // immediately, with or without a sample strobe. All other decisions wait
   // for smp_vld. Within a sample, an out-of-window temperature beats any
   // debounce that completes on the same sample.
   always_comb begin
      state_d = state_q;
      if (!en) begin
         state_d = ST_IDLE;
      end else if (smp_vld) begin
         case (state_q)
            ST_IDLE: begin
               state_d = ST_TC;
            end
            ST_TC: begin
               if (!temp_ok)      state_d = ST_FAULT;
               else if (deb_done) state_d = ST_CC;
            end
            ST_CC: begin
               if (!temp_ok)      state_d = ST_FAULT;
               else if (deb_done) state_d = ST_CV;
            end
            ST_CV: begin
               if (!temp_ok)                     state_d = ST_FAULT;
               else if (deb_done || cv_timeout) state_d = ST_DONE;
            end
            ST_DONE: begin
               if (!temp_ok)      state_d = ST_FAULT;
               else if (deb_done) state_d = ST_TC;
            end
            ST_FAULT: begin
               if (deb_done)      state_d = ST_IDLE;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // This block updates the counters and the latched capacity. A state change
   // always starts the debounce and CV counts from zero. Leaving IDLE is the
   // only moment sel is captured, so a sel change during a charge has no
   // effect. Without a state change, counters move only on sample strobes:
   // the debounce count grows on a qualifying sample and clears on any other
   // sample, and the CV count grows on every sample spent in CV.
   always_comb begin
      deb_d    = deb_q;
      cv_cnt_d = cv_cnt_q;
      cap_d    = cap_q;
      if (state_d != state_q) begin
         deb_d    = 3'd0;
         cv_cnt_d = 16'd0;
         if (state_q == ST_IDLE) begin
            cap_d = sel;
         end
      end else if (smp_vld) begin
         deb_d = qualify ? deb_inc : 3'd0;
         if (state_q == ST_CV) begin
            cv_cnt_d = cv_inc;
         end
      end
   end

   // These are the counter and capacity registers, which share the
   // synchronous reset of the state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         deb_q    <= 3'd0;
         cv_cnt_q <= 16'd0;
         cap_q    <= 4'd0;
      end else begin
         deb_q    <= deb_d;
         cv_cnt_q <= cv_cnt_d;
         cap_q    <= cap_d;
      end
   end

   // The outputs are decoded purely from the registered state and capacity.
   // The flags are therefore one-hot, or all low in IDLE. A decision taken on
   // a sample shows up right after the edge that registers that sample.
   always_comb begin
      tc    = (state_q == ST_TC);
      cc    = (state_q == ST_CC);
      cv    = (state_q == ST_CV);
      done  = (state_q == ST_DONE);
      fault = (state_q == ST_FAULT);
      case (state_q)
         ST_TC:   icode = i_end;
         ST_CC:   icode = i_cc;
         ST_CV:   icode = i_cc;
         default: icode = 8'd0;
      endcase
      case (state_q)
         ST_TC, ST_CC, ST_CV, ST_DONE: vcode = VPRE;
         default:                      vcode = 8'd0;
      endcase
   end

endmodule

// File: tb/tb_batcharger_ctrl.sv
// ----------------------------------------------------------------------------
// tb_batcharger_ctrl
//
// Purpose:
//    Self-checking bench for batcharger_ctrl. A table of directed vectors walks
//    the charger through a full charge, a debounce glitch, a recharge with a
//    sel change, and temperature faults. Hand-written sequences then cover
//    reset mid-CC, en dropping mid-CV, and the long CV timeout.
// ----------------------------------------------------------------------------
module tb_batcharger_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic [3:0] sel;
   logic       smp_vld;
   logic [7:0] vbat_code;
   logic [7:0] ibat_code;
   logic [7:0] vtemp_code;
   logic       tc, cc, cv, done, fault;
   logic [7:0] icode, vcode;

   int total = 0;
   int bad = 0;
   int early_exit = 0;
   bit mon_on = 1'b0;

   localparam logic [4:0] F_ID = 5'b00000;
   localparam logic [4:0] F_TC = 5'b10000;
   localparam logic [4:0] F_CC = 5'b01000;
   localparam logic [4:0] F_CV = 5'b00100;
   localparam logic [4:0] F_DN = 5'b00010;
   localparam logic [4:0] F_FT = 5'b00001;

   localparam int CV_TMAX = 40000;

   typedef struct {
      logic       en;
      logic [3:0] sel;
      logic       vld;
      logic [7:0] vb;
      logic [7:0] ib;
      logic [7:0] vt;
      logic [4:0] fl;
      logic [7:0] ic;
      logic [7:0] vc;
   } vec_t;

   vec_t vecs[$];

   batcharger_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .sel        (sel),
      .smp_vld    (smp_vld),
      .vbat_code  (vbat_code),
      .ibat_code  (ibat_code),
      .vtemp_code (vtemp_code),
      .tc         (tc),
      .cc         (cc),
      .cv         (cv),
      .done       (done),
      .fault      (fault),
      .icode      (icode),
      .vcode      (vcode)
   );

   // This generates a free-running clock with a 10-unit period.
   always #5 clk = ~clk;

   // This monitor runs on every falling edge and checks that no two state
   // flags are ever high together.
   always @(negedge clk) begin
      if (mon_on) begin
         total++;
         if ($countones({tc, cc, cv, done, fault}) > 1) begin
            bad++;
            $display("[TB] FAIL onehot at %0t: flags=%b required at most one set",
                     $time, {tc, cc, cv, done, fault});
         end
      end
   end

   // This adds one vector to the table: the inputs to drive for one clock and
   // the outputs required right after that edge.
   task automatic addVec(input logic e, input logic [3:0] s, input logic v,
                         input logic [7:0] vb, input logic [7:0] ib,
                         input logic [7:0] vt, input logic [4:0] fl,
                         input logic [7:0] ic, input logic [7:0] vc);
      vec_t x;
      x.en  = e;
      x.sel = s;
      x.vld = v;
      x.vb  = vb;
      x.ib  = ib;
      x.vt  = vt;
      x.fl  = fl;
      x.ic  = ic;
      x.vc  = vc;
      vecs.push_back(x);
   endtask

   // This drives one clock's worth of inputs, waits for the edge, and then
   // settles 1 unit past it so the outputs can be sampled safely.
   task automatic applyStimulus(input logic e, input logic [3:0] s, input logic v,
                                input logic [7:0] vb, input logic [7:0] ib,
                                input logic [7:0] vt);
      en         = e;
      sel        = s;
      smp_vld    = v;
      vbat_code  = vb;
      ibat_code  = ib;
      vtemp_code = vt;
      @(posedge clk);
      #1;
   endtask

   // This compares the state flags, icode and vcode against the required
   // values, logging one FAIL line per miscompare.
   task automatic checkOutput(input string name, input logic [4:0] fl,
                              input logic [7:0] ic, input logic [7:0] vc);
      total++;
      if ({tc, cc, cv, done, fault} !== fl) begin
         bad++;
         $display("[TB] FAIL %s flags: got %b required %b", name,
                  {tc, cc, cv, done, fault}, fl);
      end
      total++;
      if (icode !== ic) begin
         bad++;
         $display("[TB] FAIL %s icode: got %0d required %0d", name, icode, ic);
      end
      total++;
      if (vcode !== vc) begin
         bad++;
         $display("[TB] FAIL %s vcode: got %0d required %0d", name, vcode, vc);
      end
   endtask

   // This is the main test: reset, the vector table, and then the
   // hand-written multi-cycle sequences.
   initial begin
      // Table columns: en sel vld vbat ibat vtemp | flags icode vcode.
      // Full charge with sel=8, giving I_TC=I_END=9 and I_CC=90.
      addVec(1, 8, 0, 140, 100, 100, F_ID, 0, 0);
      addVec(1, 8, 1, 140, 100, 100, F_TC, 9, 210);
      addVec(1, 8, 1, 145, 100, 100, F_TC, 9, 210);
      addVec(1, 8, 1, 150, 100, 100, F_TC, 9, 210);
      addVec(1, 8, 1, 160, 100, 100, F_TC, 9, 210);
      addVec(1, 8, 0, 100, 100, 100, F_TC, 9, 210);
      addVec(1, 8, 1, 170, 100, 100, F_TC, 9, 210);
      addVec(1, 8, 1, 180, 100, 100, F_CC, 90, 210);
      addVec(1, 8, 1, 205, 100, 100, F_CC, 90, 210);
      addVec(1, 8, 1, 210, 100, 100, F_CC, 90, 210);
      addVec(1, 8, 1, 212, 100, 100, F_CC, 90, 210);
      addVec(1, 8, 1, 215, 100, 100, F_CC, 90, 210);
      addVec(1, 8, 1, 215, 100, 100, F_CV, 90, 210);
      addVec(1, 8, 1, 215,  50, 100, F_CV, 90, 210);
      addVec(1, 8, 1, 215,  20, 100, F_CV, 90, 210);
      addVec(1, 8, 1, 215,   8, 100, F_CV, 90, 210);
      addVec(1, 8, 1, 215,   9, 100, F_CV, 90, 210);
      addVec(1, 8, 1, 215,   5, 100, F_CV, 90, 210);
      addVec(1, 8, 1, 215,   8, 100, F_DN, 0, 210);
      // Recharge with sel changed to 0; vbat=195 is not below VRECH.
      addVec(1, 0, 1, 215,   0, 100, F_DN, 0, 210);
      addVec(1, 0, 1, 190,   0, 100, F_DN, 0, 210);
      addVec(1, 0, 1, 190,   0, 100, F_DN, 0, 210);
      addVec(1, 0, 1, 195,   0, 100, F_DN, 0, 210);
      addVec(1, 0, 1, 190,   0, 100, F_DN, 0, 210);
      addVec(1, 0, 1, 190,   0, 100, F_DN, 0, 210);
      addVec(1, 0, 1, 190,   0, 100, F_DN, 0, 210);
      addVec(1, 0, 1, 190,   0, 100, F_TC, 9, 210);
      // Debounce glitch in TC.
      addVec(1, 0, 1, 150, 100, 100, F_TC, 9, 210);
      addVec(1, 0, 1, 150, 100, 100, F_TC, 9, 210);
      addVec(1, 0, 1, 150, 100, 100, F_TC, 9, 210);
      addVec(1, 0, 1, 149, 100, 100, F_TC, 9, 210);
      addVec(1, 0, 1, 150, 100, 100, F_TC, 9, 210);
      addVec(1, 0, 1, 150, 100, 100, F_TC, 9, 210);
      addVec(1, 0, 1, 150, 100, 100, F_TC, 9, 210);
      addVec(1, 0, 1, 150, 100, 100, F_CC, 90, 210);
      // Hot trip in CC, then recovery with in-window edges 131 and 62.
      addVec(1, 0, 1, 150, 100, 140, F_FT, 0, 0);
      addVec(1, 0, 1, 150, 100, 100, F_FT, 0, 0);
      addVec(1, 0, 1, 150, 100, 100, F_FT, 0, 0);
      addVec(1, 0, 1, 150, 100, 131, F_FT, 0, 0);
      addVec(1, 0, 1, 150, 100,  62, F_ID, 0, 0);
      // Restart with sel=3 (I_TC=4); the fault wins over a completing debounce.
      addVec(1, 3, 1, 140, 100, 100, F_TC, 4, 210);
      addVec(1, 3, 1, 150, 100, 100, F_TC, 4, 210);
      addVec(1, 3, 1, 150, 100, 100, F_TC, 4, 210);
      addVec(1, 3, 1, 150, 100, 100, F_TC, 4, 210);
      addVec(1, 3, 1, 150, 100, 140, F_FT, 0, 0);
      // Cold sample and a glitch at 132 both restart the recovery debounce.
      addVec(1, 3, 1, 150, 100,  61, F_FT, 0, 0);
      addVec(1, 3, 1, 150, 100, 100, F_FT, 0, 0);
      addVec(1, 3, 1, 150, 100, 100, F_FT, 0, 0);
      addVec(1, 3, 1, 150, 100, 100, F_FT, 0, 0);
      addVec(1, 3, 1, 150, 100, 132, F_FT, 0, 0);
      addVec(1, 3, 1, 150, 100, 100, F_FT, 0, 0);
      addVec(1, 3, 1, 150, 100, 100, F_FT, 0, 0);
      addVec(1, 3, 1, 150, 100, 100, F_FT, 0, 0);
      addVec(1, 3, 1, 150, 100, 100, F_ID, 0, 0);
      addVec(0, 3, 1, 150, 100, 100, F_ID, 0, 0);

      // Apply reset with a sample strobe and enable active; reset must still
      // win and leave everything at zero.
      rst        = 1'b1;
      en         = 1'b1;
      sel        = 4'd5;
      smp_vld    = 1'b1;
      vbat_code  = 8'd140;
      ibat_code  = 8'd100;
      vtemp_code = 8'd100;
      @(posedge clk);
      @(posedge clk);
      #1;
      mon_on = 1'b1;
      checkOutput("reset", F_ID, 0, 0);
      rst     = 1'b0;
      en      = 1'b0;
      smp_vld = 1'b0;
      @(posedge clk);
      #1;

      // Run the vector table.
      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i].en, vecs[i].sel, vecs[i].vld,
                       vecs[i].vb, vecs[i].ib, vecs[i].vt);
         checkOutput($sformatf("vec%0d", i), vecs[i].fl, vecs[i].ic, vecs[i].vc);
      end

      // Reset asserted mid-CC aborts to IDLE on the next clock.
      applyStimulus(1, 8, 1, 140, 100, 100);
      checkOutput("seqA_tc", F_TC, 9, 210);
      for (int i = 0; i < 4; i++) applyStimulus(1, 8, 1, 160, 100, 100);
      checkOutput("seqA_cc", F_CC, 90, 210);
      rst = 1'b1;
      applyStimulus(1, 8, 1, 215, 100, 100);
      checkOutput("rst_mid_cc", F_ID, 0, 0);
      rst = 1'b0;

      // Dropping en mid-CV, with no strobe, returns to IDLE on the next clock.
      applyStimulus(1, 2, 1, 140, 100, 100);
      checkOutput("seqB_tc", F_TC, 3, 210);
      for (int i = 0; i < 4; i++) applyStimulus(1, 2, 1, 160, 100, 100);
      checkOutput("seqB_cc", F_CC, 30, 210);
      for (int i = 0; i < 4; i++) applyStimulus(1, 2, 1, 215, 100, 100);
      checkOutput("seqB_cv", F_CV, 30, 210);
      applyStimulus(0, 2, 0, 215, 100, 100);
      checkOutput("en_off_mid_cv", F_ID, 0, 0);

      // CV timeout: ibat stays high, so only the sample count can end CV.
      // Gaps without a strobe must not advance the count.
      applyStimulus(1, 8, 1, 140, 200, 100);
      for (int i = 0; i < 4; i++) applyStimulus(1, 8, 1, 160, 200, 100);
      for (int i = 0; i < 4; i++) applyStimulus(1, 8, 1, 215, 200, 100);
      checkOutput("seqC_cv", F_CV, 90, 210);
      for (int i = 1; i < CV_TMAX; i++) begin
         applyStimulus(1, 8, 1, 215, 200, 100);
         if (cv !== 1'b1) early_exit++;
         if (i % 1000 == 0) begin
            applyStimulus(1, 8, 0, 215, 200, 100);
            if (cv !== 1'b1) early_exit++;
         end
      end
      total++;
      if (early_exit != 0) begin
         bad++;
         $display("[TB] FAIL cv_hold: cycles out of CV before timeout got %0d required 0",
                  early_exit);
      end
      checkOutput("cv_before_tmax", F_CV, 90, 210);
      applyStimulus(1, 8, 1, 215, 200, 100);
      checkOutput("cv_timeout", F_DN, 0, 210);

      mon_on = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/batcharger_ctrl.md
BATCHARGER_CTRL -- requirements
Module: batcharger_ctrl

Interface
REQ-001 The module SHALL have the following parameters:
- DEBOUNCE, 4: consecutive qualifying samples required for any data-driven transition.
- VCUT, 150: TC->CC threshold, 3.00 V at 20 mV/LSB.
- VPRE, 210: CV target and CC->CV threshold, 4.20 V.
- VRECH, 195: recharge threshold from DONE, 3.90 V.
- TLO, 62: temperature low limit, 0 °C.
- THI, 131: temperature high limit, 45 °C.
- CV_TMAX, 40000: CV timeout in samples.

REQ-002 The module SHALL have the following ports; clock is clk and reset is rst, one clock domain, synchronous active-high reset:
- clk, in, 1: clock.
- rst, in, 1: synchronous active-high reset.
- en, in, 1: charger enable.
- sel, in, 4: capacity select; C = 50*(sel+1) mAh.
- smp_vld, in, 1: one-cycle strobe; the ADC codes below are valid.
- vbat_code, in, 8: battery voltage, 20 mV/LSB.
- ibat_code, in, 8: battery current, 5 mA/LSB.
- vtemp_code, in, 8: temperature code, 0..255 = -40..125 °C.
- tc, out, 1: trickle-charge state active.
- cc, out, 1: constant-current state active.
- cv, out, 1: constant-voltage state active.
- done, out, 1: charge complete.
- fault, out, 1: temperature fault.
- icode, out, 8: current DAC command, 5 mA/LSB.
- vcode, out, 8: voltage DAC target, 20 mV/LSB.

Function
REQ-003 The FSM SHALL have the states IDLE, TC, CC, CV, DONE and FAULT, each with a registered state register.
REQ-004 Outputs tc/cc/cv/done/fault SHALL be decoded from the state register so that at most one is high, and all are low in IDLE.
REQ-005 The FSM SHALL evaluate conditions only in cycles where smp_vld=1; with smp_vld=0, state, counters and outputs SHALL hold.
REQ-006 A transition decided on sample N SHALL be visible on the outputs on the clock edge that registers sample N, i.e. one-cycle latency from the smp_vld cycle.
REQ-007 The module SHALL use one shared debounce counter of 3 bits, saturating at DEBOUNCE, that increments on a qualifying sample, clears on a non-qualifying sample, and clears on every state change.
REQ-008 In IDLE with en=1, the FSM SHALL latch sel into cap_q and go to TC on the next sample.
REQ-009 cap_q SHALL be used for all current computations until the FSM returns to IDLE; sel changes mid-charge SHALL be ignored.
REQ-010 The current codes SHALL be derived from cap_q as follows:
- I_CC = 10*(cap_q+1), width 8, maximum 160.
- I_TC = I_END = cap_q+1.
REQ-011 In TC: icode = I_TC and vcode = VPRE; go to CC after DEBOUNCE samples with vbat_code >= VCUT.
REQ-012 In CC: icode = I_CC and vcode = VPRE; go to CV after DEBOUNCE samples with vbat_code >= VPRE.
REQ-013 In CV: icode = I_CC as the current limit and vcode = VPRE.
REQ-014 The CV exit condition SHALL be:
- go to DONE after DEBOUNCE samples with ibat_code <= I_END; or
- go to DONE when the 16-bit CV sample counter reaches CV_TMAX, whichever occurs first.
REQ-015 The CV sample counter SHALL clear on CV entry and SHALL NOT wrap.
REQ-016 In DONE: icode = 0 and vcode = VPRE; go to TC after DEBOUNCE samples with vbat_code < VRECH.
REQ-017 From TC, CC, CV or DONE, a single sample with vtemp_code < TLO or vtemp_code > THI SHALL force FAULT, with no debounce.
REQ-018 In FAULT: icode = 0 and vcode = 0; go to IDLE after DEBOUNCE samples with TLO <= vtemp_code <= THI.
REQ-019 The FSM SHALL go to IDLE on the next clock whenever en=0, regardless of smp_vld; this has priority over every other transition.
REQ-020 When the temperature fault and a debounce completion coincide on one sample, FAULT SHALL win.
REQ-021 In IDLE: icode = 0 and vcode = 0.

Reset
REQ-022 With rst=1 at a clock edge, the module SHALL set state=IDLE, all flags to 0, icode=0, vcode=0, cap_q=0 and all counters to 0.
REQ-023 Reset asserted mid-charge SHALL abort immediately, with no graceful ramp.
REQ-024 rst SHALL take priority over en and smp_vld.

Verification
REQ-025 Full cycle: sel=4'b1000, en=1, vbat ramps 140->215, then ibat falls to 8. Required sequence: TC(icode=9) -> CC(icode=90) -> CV -> DONE(icode=0), with each step after exactly 4 qualifying samples.
REQ-026 Debounce glitch: in TC, 3 samples at vbat=150, 1 at 149, 3 at 150. The FSM SHALL stay in TC; the 4th consecutive sample at 150 moves it to CC.
REQ-027 Temperature: in CC, one sample with vtemp=140 -> fault=1, icode=0, vcode=0 next cycle. Then 4 samples at vtemp=100 -> IDLE -> TC.
REQ-028 CV timeout: hold ibat=200 in CV. done=1 when the CV sample count reaches CV_TMAX; the FSM SHALL NOT leave CV earlier.
REQ-029 Recharge plus sel change: in DONE, drive sel=4'b0000 and then vbat=190 for 4 samples. The FSM SHALL return to TC with icode=9, because cap_q is unchanged.
REQ-030 en and rst checks, asserted at every state:
- en=0 mid-CV -> IDLE with all outputs 0 on the next clock.
- rst=1 mid-CC -> IDLE with all outputs 0 on the next clock.
- tc+cc+cv+done+fault <= 1 at every cycle.
